trap_ctrl: RTL and testbench
============================

Name: trap_ctrl

Overview:
- Trap sequencer downstream of the CSR block's interrupt gating and upstream of its trap CSR channel.
- On an exception, a masked interrupt request, or `mret`, it stalls the core and performs the machine-mode CSR save or restore sequence over the trap channel, one CSR per cycle.
- It then issues a single-cycle redirect of the fetch stage to `mtvec` or `mepc`.

Parameters:
- XLEN, 32, data/address width; must match `RegBus`.
- VECTORED_EN, 1, when 1, honour `mtvec[1:0]==01` vectored mode for interrupts.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- hx_valid  in  1  instruction retires this cycle; this is the only point where interrupts are accepted
- inst_pc_i  in  XLEN  PC of the instruction in ex
- next_pc_i  in  XLEN  PC of the next sequential/target instruction
- inst_i  in  XLEN  instruction word in ex
- ecall_i / ebreak_i / illegal_i / mret_i  in  1 each  ex-stage decode flags
- ex_trap_valid_i / tcmp_trap_valid_i / soft_trap_valid_i  in  1 each  masked interrupt requests from the CSR block
- mstatus_MIE3_i  in  1  global interrupt enable
- trap_csr_we_o  out  1  trap channel write enable
- trap_csr_addr_o  out  12  trap channel CSR address (`CsrAddrBus`)
- trap_csr_wdata_o  out  XLEN  trap channel write data
- trap_csr_rdata_i  in  XLEN  trap channel combinational read data
- trap_stall_o  out  1  hold pipeline and suppress idex CSR writes
- trap_jump_o  out  1  one-cycle fetch redirect strobe
- trap_jump_addr_o  out  XLEN  redirect target

Behaviour:

Reset:
- State goes to IDLE. All outputs are 0, and internal cause/epc/tval registers are 0.
- Reset asserted mid-sequence aborts it immediately. Partially written CSRs keep their values.

Event detection (IDLE only):
- exc = ecall_i | ebreak_i | illegal_i
- irq = hx_valid & mstatus_MIE3_i & (ex | soft | tcmp)
- Priority: exc > mret_i > irq.
- Exception sub-priority: illegal > ebreak > ecall.
- Interrupt sub-priority: ext > soft > timer.

Latched values on acceptance:
- mcause:
  - illegal = 2
  - ebreak = 3
  - ecall = 11
  - ext = 0x8000000B
  - soft = 0x80000003
  - timer = 0x80000007
- epc: `inst_pc_i` for an exception; `next_pc_i` for an interrupt.
- tval: `inst_i` for illegal; `inst_pc_i` for ebreak; 0 otherwise.

Stall:
- `trap_stall_o` = (IDLE & accepted event) | (state != IDLE & state != JUMP).
- `trap_stall_o` is low in JUMP, so the pipeline restarts on the redirected fetch.

Trap FSM (one state per cycle, we=1 in every W_* state):
- IDLE → W_MEPC: write `mepc` = epc.
- → W_MCAUSE: write `mcause`.
- → W_MTVAL: write `mtval` = tval.
- → W_MSTATUS:
  - read `mstatus` via rdata, in the same cycle as the write.
  - write it with bit7 (MPIE) = old bit3, bit3 (MIE) = 0, other bits as read.
- → RD_MTVEC: addr = `CSR_MTVEC`, we = 0; latch target.
  - target = {mtvec[XLEN-1:2], 2'b00}
  - if VECTORED_EN, `mtvec[1:0]==01` and the cause is an interrupt: target += 4 × mcause[4:0]
- → JUMP: `trap_jump_o` = 1 for exactly one cycle, with `trap_jump_addr_o` = target.
- → IDLE.
- Event-to-jump latency: accept at cycle N, jump at cycle N+5.

mret FSM:
- IDLE → R_MSTATUS: write `mstatus` with MIE = old MPIE, MPIE = 1.
- → RD_MEPC: addr = `CSR_MEPC`; latch target = rdata & ~3.
- → JUMP → IDLE.
- Latency: jump at N+2.

Other rules:
- Requests arriving while not in IDLE are ignored; the interrupt remains pending at its source.
- `trap_csr_addr_o` and `trap_csr_wdata_o` are 0 in IDLE and JUMP.
- `trap_jump_addr_o` holds its last value when `trap_jump_o` = 0.
- All addresses use the codebase `CSR_*` defines.

Test Plan:
- **ecall:** ecall_i at `inst_pc_i`=0x100, `mtvec`=0x200 → writes in order: `mepc`=0x100, `mcause`=11, `mtval`=0, `mstatus` MIE 1→0 / MPIE=1; jump to 0x200 exactly 5 cycles after accept.
- **Vectored timer interrupt:** `mtvec`=0x301, tcmp_trap_valid_i=1, MIE=1, hx_valid with `next_pc_i`=0x40 → `mepc`=0x40, `mcause`=0x80000007, jump to 0x31C.
- **Simultaneous requests:** illegal_i with `inst_i`=0xFFFFFFFF plus ext irq → exception wins: `mcause`=2, `mtval`=0xFFFFFFFF; ext+soft+timer with no exception → `mcause`=0x8000000B.
- **Masking:** irq with MIE=0, or with hx_valid=0 → no stall, no CSR write, no jump.
- **mret:** `mepc`=0x1234 (low bits 00), MPIE=1 → `mstatus` MIE=1 / MPIE=1; jump to 0x1234 at N+2; mret_i together with ecall_i → ecall sequence only.
- **Reset mid-sequence:** rst_n low during W_MCAUSE → outputs 0 that same cycle, state IDLE; after release a new ecall runs the full sequence.

Source files
------------

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer.
//
// Sits between the CSR block's interrupt gating and its trap CSR channel. It accepts one of
// three kinds of event while idle:
//   * an ex-stage exception (illegal, ebreak, ecall),
//   * mret,
//   * a masked interrupt request.
// For the accepted event it stalls the core, walks the machine-mode CSR save or restore
// sequence one CSR per cycle, and then pulses a single-cycle fetch redirect.
//
// Ports:
//   clk, rst_n            core clock, asynchronous active-low reset
//   hx_valid              an instruction retires this cycle (interrupt acceptance point)
//   inst_pc_i, next_pc_i  PC of the ex instruction / PC of the next instruction
//   inst_i                ex instruction word (mtval for illegal instructions)
//   ecall_i .. mret_i     ex-stage decode flags
//   *_trap_valid_i        masked interrupt requests (external, timer, software)
//   mstatus_MIE3_i        global interrupt enable
//   trap_csr_*            trap CSR channel (we/addr/wdata out, combinational rdata in)
//   trap_stall_o          hold the pipeline and suppress idex CSR writes
//   trap_jump_o           one-cycle fetch redirect strobe
//   trap_jump_addr_o      redirect target; holds its last value between jumps

`ifndef CSR_MSTATUS
`define CSR_MSTATUS 12'h300
`endif
`ifndef CSR_MTVEC
`define CSR_MTVEC 12'h305
`endif
`ifndef CSR_MEPC
`define CSR_MEPC 12'h341
`endif
`ifndef CSR_MCAUSE
`define CSR_MCAUSE 12'h342
`endif
`ifndef CSR_MTVAL
`define CSR_MTVAL 12'h343
`endif

module trap_ctrl #(
  parameter int unsigned XLEN        = 32,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hx_valid,
  input  logic [XLEN-1:0] inst_pc_i,
  input  logic [XLEN-1:0] next_pc_i,
  input  logic [XLEN-1:0] inst_i,
  input  logic            ecall_i,
  input  logic            ebreak_i,
  input  logic            illegal_i,
  input  logic            mret_i,
  input  logic            ex_trap_valid_i,
  input  logic            tcmp_trap_valid_i,
  input  logic            soft_trap_valid_i,
  input  logic            mstatus_MIE3_i,
  output logic            trap_csr_we_o,
  output logic [11:0]     trap_csr_addr_o,
  output logic [XLEN-1:0] trap_csr_wdata_o,
  input  logic [XLEN-1:0] trap_csr_rdata_i,
  output logic            trap_stall_o,
  output logic            trap_jump_o,
  output logic [XLEN-1:0] trap_jump_addr_o
);

  localparam logic [XLEN-1:0] CauseIllegal = XLEN'(2);
  localparam logic [XLEN-1:0] CauseEbreak  = XLEN'(3);
  localparam logic [XLEN-1:0] CauseEcall   = XLEN'(11);
  localparam logic [XLEN-1:0] CauseExt     = {1'b1, {(XLEN-5){1'b0}}, 4'hB};
  localparam logic [XLEN-1:0] CauseSoft    = {1'b1, {(XLEN-5){1'b0}}, 4'h3};
  localparam logic [XLEN-1:0] CauseTimer   = {1'b1, {(XLEN-5){1'b0}}, 4'h7};

  typedef enum logic [3:0] {
    StIdle,
    StWMepc,
    StWMcause,
    StWMtval,
    StWMstatus,
    StRdMtvec,
    StRMstatus,
    StRdMepc,
    StJump
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] cause_q;
  logic [XLEN-1:0] epc_q;
  logic [XLEN-1:0] tval_q;
  logic [XLEN-1:0] target_q;

  logic            exc;
  logic            irq;
  logic            accept;
  logic [XLEN-1:0] exc_cause;
  logic [XLEN-1:0] exc_tval;
  logic [XLEN-1:0] irq_cause;
  logic [XLEN-1:0] mstatus_trap;
  logic [XLEN-1:0] mstatus_mret;
  logic [XLEN-1:0] vec_target;

  // Event detection and cause/tval selection.
  always_comb begin
    exc = ecall_i | ebreak_i | illegal_i;
    irq = hx_valid & mstatus_MIE3_i & (ex_trap_valid_i | soft_trap_valid_i | tcmp_trap_valid_i);
    // Gated by rst_n so that every output is low while reset is held.
    accept = rst_n & (state_q == StIdle) & (exc | mret_i | irq);

    if (illegal_i) begin
      exc_cause = CauseIllegal;
      exc_tval  = inst_i;
    end else if (ebreak_i) begin
      exc_cause = CauseEbreak;
      exc_tval  = inst_pc_i;
    end else begin
      exc_cause = CauseEcall;
      exc_tval  = '0;
    end

    if (ex_trap_valid_i) begin
      irq_cause = CauseExt;
    end else if (soft_trap_valid_i) begin
      irq_cause = CauseSoft;
    end else begin
      irq_cause = CauseTimer;
    end
  end

  // mstatus rewrites are computed from the same-cycle read data of the trap channel.
  always_comb begin
    mstatus_trap    = trap_csr_rdata_i;
    mstatus_trap[7] = trap_csr_rdata_i[3];
    mstatus_trap[3] = 1'b0;

    mstatus_mret    = trap_csr_rdata_i;
    mstatus_mret[3] = trap_csr_rdata_i[7];
    mstatus_mret[7] = 1'b1;

    vec_target = {trap_csr_rdata_i[XLEN-1:2], 2'b00};
    // Vectored mode only applies to interrupts; exceptions always land on the base.
    if (VECTORED_EN && (trap_csr_rdata_i[1:0] == 2'b01) && cause_q[XLEN-1]) begin
      vec_target = vec_target + {{(XLEN-7){1'b0}}, cause_q[4:0], 2'b00};
    end
  end

  // Sequencer state and latched trap context.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cause_q  <= '0;
      epc_q    <= '0;
      tval_q   <= '0;
      target_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (exc) begin
            state_q <= StWMepc;
            cause_q <= exc_cause;
            epc_q   <= inst_pc_i;
            tval_q  <= exc_tval;
          end else if (mret_i) begin
            state_q <= StRMstatus;
          end else if (irq) begin
            state_q <= StWMepc;
            cause_q <= irq_cause;
            epc_q   <= next_pc_i;
            tval_q  <= '0;
          end
        end
        StWMepc:    state_q <= StWMcause;
        StWMcause:  state_q <= StWMtval;
        StWMtval:   state_q <= StWMstatus;
        StWMstatus: state_q <= StRdMtvec;
        StRdMtvec: begin
          target_q <= vec_target;
          state_q  <= StJump;
        end
        StRMstatus: state_q <= StRdMepc;
        StRdMepc: begin
          target_q <= trap_csr_rdata_i & ~XLEN'(3);
          state_q  <= StJump;
        end
        StJump:     state_q <= StIdle;
        default:    state_q <= StIdle;
      endcase
    end
  end

  // Channel drive decoded from the current state.
  always_comb begin
    trap_csr_we_o    = 1'b0;
    trap_csr_addr_o  = '0;
    trap_csr_wdata_o = '0;
    trap_jump_o      = 1'b0;
    trap_stall_o     = accept | ((state_q != StIdle) && (state_q != StJump));
    case (state_q)
      StWMepc: begin
        trap_csr_we_o    = 1'b1;
        trap_csr_addr_o  = `CSR_MEPC;
        trap_csr_wdata_o = epc_q;
      end
      StWMcause: begin
        trap_csr_we_o    = 1'b1;
        trap_csr_addr_o  = `CSR_MCAUSE;
        trap_csr_wdata_o = cause_q;
      end
      StWMtval: begin
        trap_csr_we_o    = 1'b1;
        trap_csr_addr_o  = `CSR_MTVAL;
        trap_csr_wdata_o = tval_q;
      end
      StWMstatus: begin
        trap_csr_we_o    = 1'b1;
        trap_csr_addr_o  = `CSR_MSTATUS;
        trap_csr_wdata_o = mstatus_trap;
      end
      StRdMtvec: begin
        trap_csr_addr_o  = `CSR_MTVEC;
      end
      StRMstatus: begin
        trap_csr_we_o    = 1'b1;
        trap_csr_addr_o  = `CSR_MSTATUS;
        trap_csr_wdata_o = mstatus_mret;
      end
      StRdMepc: begin
        trap_csr_addr_o  = `CSR_MEPC;
      end
      StJump: begin
        trap_jump_o      = 1'b1;
      end
      default: ;
    endcase
  end

  assign trap_jump_addr_o = target_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: a small CSR file answers the trap channel, a table of
// directed events is run through the sequencer, and reset behaviour is exercised by hand.
module tb_trap_ctrl;

  logic        clk;
  logic        rst_n;
  logic        hx_valid;
  logic [31:0] inst_pc_i;
  logic [31:0] next_pc_i;
  logic [31:0] inst_i;
  logic        ecall_i;
  logic        ebreak_i;
  logic        illegal_i;
  logic        mret_i;
  logic        ex_trap_valid_i;
  logic        tcmp_trap_valid_i;
  logic        soft_trap_valid_i;
  logic        mstatus_MIE3_i;
  logic        trap_csr_we_o;
  logic [11:0] trap_csr_addr_o;
  logic [31:0] trap_csr_wdata_o;
  logic [31:0] trap_csr_rdata_i;
  logic        trap_stall_o;
  logic        trap_jump_o;
  logic [31:0] trap_jump_addr_o;

  trap_ctrl #(
    .XLEN        (32),
    .VECTORED_EN (1'b1)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .hx_valid          (hx_valid),
    .inst_pc_i         (inst_pc_i),
    .next_pc_i         (next_pc_i),
    .inst_i            (inst_i),
    .ecall_i           (ecall_i),
    .ebreak_i          (ebreak_i),
    .illegal_i         (illegal_i),
    .mret_i            (mret_i),
    .ex_trap_valid_i   (ex_trap_valid_i),
    .tcmp_trap_valid_i (tcmp_trap_valid_i),
    .soft_trap_valid_i (soft_trap_valid_i),
    .mstatus_MIE3_i    (mstatus_MIE3_i),
    .trap_csr_we_o     (trap_csr_we_o),
    .trap_csr_addr_o   (trap_csr_addr_o),
    .trap_csr_wdata_o  (trap_csr_wdata_o),
    .trap_csr_rdata_i  (trap_csr_rdata_i),
    .trap_stall_o      (trap_stall_o),
    .trap_jump_o       (trap_jump_o),
    .trap_jump_addr_o  (trap_jump_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CSR file model with a write log.
  logic        load_en;
  logic [31:0] ld_mstatus, ld_mtvec, ld_mepc;
  logic [31:0] csr_mstatus, csr_mtvec, csr_mepc, csr_mcause, csr_mtval;
  logic [11:0] wlog_addr [8];
  logic [31:0] wlog_data [8];
  int          wcnt;

  always @(posedge clk) begin
    if (load_en) begin
      csr_mstatus <= ld_mstatus;
      csr_mtvec   <= ld_mtvec;
      csr_mepc    <= ld_mepc;
      csr_mcause  <= 32'h0000_00FF;
      csr_mtval   <= 32'hAAAA_AAAA;
      wcnt        <= 0;
    end else if (trap_csr_we_o) begin
      case (trap_csr_addr_o)
        12'h300: csr_mstatus <= trap_csr_wdata_o;
        12'h305: csr_mtvec   <= trap_csr_wdata_o;
        12'h341: csr_mepc    <= trap_csr_wdata_o;
        12'h342: csr_mcause  <= trap_csr_wdata_o;
        12'h343: csr_mtval   <= trap_csr_wdata_o;
        default: ;
      endcase
      if (wcnt < 8) begin
        wlog_addr[wcnt] <= trap_csr_addr_o;
        wlog_data[wcnt] <= trap_csr_wdata_o;
      end
      wcnt <= wcnt + 1;
    end
  end

  always_comb begin
    case (trap_csr_addr_o)
      12'h300: trap_csr_rdata_i = csr_mstatus;
      12'h305: trap_csr_rdata_i = csr_mtvec;
      12'h341: trap_csr_rdata_i = csr_mepc;
      12'h342: trap_csr_rdata_i = csr_mcause;
      12'h343: trap_csr_rdata_i = csr_mtval;
      default: trap_csr_rdata_i = 32'h0;
    endcase
  end

  int nchecks = 0;
  int nerrors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // ev = {ecall, ebreak, illegal, mret, ext, soft, timer}
  task automatic set_ev(input logic [6:0] ev);
    {ecall_i, ebreak_i, illegal_i, mret_i, ex_trap_valid_i, soft_trap_valid_i,
     tcmp_trap_valid_i} = ev;
  endtask

  typedef struct {
    string       name;
    logic [6:0]  ev;
    logic        hx;
    logic        mie;
    logic [31:0] inst_pc;
    logic [31:0] next_pc;
    logic [31:0] inst;
    logic [31:0] mstatus0;
    logic [31:0] mtvec0;
    logic [31:0] mepc0;
    logic        exp_act;
    int          exp_lat;     // jump cycle index after the accepting edge, -1 for none
    logic [31:0] exp_jaddr;
    logic [31:0] exp_mepc;
    logic [31:0] exp_mcause;
    logic [31:0] exp_mtval;
    logic [31:0] exp_mstatus;
    int          exp_nwr;
  } vec_t;

  vec_t vecs [11];

  task automatic load_csrs(input logic [31:0] ms, input logic [31:0] tv, input logic [31:0] ep);
    @(negedge clk);
    set_ev(7'b0);
    hx_valid   = 1'b0;
    load_en    = 1'b1;
    ld_mstatus = ms;
    ld_mtvec   = tv;
    ld_mepc    = ep;
    @(negedge clk);
    load_en    = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int          jat;
    int          njump;
    logic [31:0] jad;
    logic [11:0] eaddr [4];
    logic [31:0] edata [4];
    jat   = -1;
    njump = 0;
    jad   = 32'h0;
    load_csrs(v.mstatus0, v.mtvec0, v.mepc0);
    set_ev(v.ev);
    hx_valid       = v.hx;
    mstatus_MIE3_i = v.mie;
    inst_pc_i      = v.inst_pc;
    next_pc_i      = v.next_pc;
    inst_i         = v.inst;
    #1;
    chk({v.name, " accept_stall"}, {31'b0, trap_stall_o}, {31'b0, v.exp_act});
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      chk({v.name, " stall"}, {31'b0, trap_stall_o},
          {31'b0, v.exp_act && (k < v.exp_lat)});
      if (trap_jump_o) begin
        njump++;
        if (jat < 0) begin
          jat = k;
          jad = trap_jump_addr_o;
        end
        chk({v.name, " jump_bus_idle"}, {19'b0, trap_csr_we_o, trap_csr_addr_o},
            32'h0);
        chk({v.name, " jump_wdata_idle"}, trap_csr_wdata_o, 32'h0);
      end
      set_ev(7'b0);
      hx_valid = 1'b0;
      @(negedge clk);
    end
    chk({v.name, " jump_cycle"}, jat, v.exp_lat);
    chk({v.name, " jump_count"}, njump, v.exp_act ? 1 : 0);
    if (v.exp_act) chk({v.name, " jump_addr_strobe"}, jad, v.exp_jaddr);
    chk({v.name, " jump_addr_hold"}, trap_jump_addr_o, v.exp_jaddr);
    chk({v.name, " idle_bus"}, {19'b0, trap_csr_we_o, trap_csr_addr_o}, 32'h0);
    chk({v.name, " mepc"}, csr_mepc, v.exp_mepc);
    chk({v.name, " mcause"}, csr_mcause, v.exp_mcause);
    chk({v.name, " mtval"}, csr_mtval, v.exp_mtval);
    chk({v.name, " mstatus"}, csr_mstatus, v.exp_mstatus);
    chk({v.name, " nwrites"}, wcnt, v.exp_nwr);
    if (v.exp_nwr == 4 && wcnt == 4) begin
      eaddr = '{12'h341, 12'h342, 12'h343, 12'h300};
      edata = '{v.exp_mepc, v.exp_mcause, v.exp_mtval, v.exp_mstatus};
      for (int i = 0; i < 4; i++) begin
        chk({v.name, " wr_order_addr"}, {20'b0, wlog_addr[i]}, {20'b0, eaddr[i]});
        chk({v.name, " wr_order_data"}, wlog_data[i], edata[i]);
      end
    end else if (v.exp_nwr == 1 && wcnt == 1) begin
      chk({v.name, " mret_wr_addr"}, {20'b0, wlog_addr[0]}, 32'h300);
      chk({v.name, " mret_wr_data"}, wlog_data[0], v.exp_mstatus);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " stall"}, {31'b0, trap_stall_o}, 32'h0);
    chk({nm, " we"}, {31'b0, trap_csr_we_o}, 32'h0);
    chk({nm, " addr"}, {20'b0, trap_csr_addr_o}, 32'h0);
    chk({nm, " wdata"}, trap_csr_wdata_o, 32'h0);
    chk({nm, " jump"}, {31'b0, trap_jump_o}, 32'h0);
    chk({nm, " jump_addr"}, trap_jump_addr_o, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    //            name           ev           hx    mie   inst_pc    next_pc    inst
    //            mstatus0 mtvec0 mepc0  act lat jaddr mepc mcause mtval mstatus nwr
    vecs[0]  = '{"ecall", 7'b1000000, 1'b0, 1'b1, 32'h100, 32'h104, 32'h73,
                 32'h8, 32'h200, 32'h0, 1'b1, 5, 32'h200, 32'h100, 32'd11, 32'h0, 32'h80, 4};
    vecs[1]  = '{"timer_vec", 7'b0000001, 1'b1, 1'b1, 32'h3C, 32'h40, 32'h13,
                 32'h8, 32'h301, 32'h0, 1'b1, 5, 32'h31C, 32'h40, 32'h8000_0007, 32'h0,
                 32'h80, 4};
    vecs[2]  = '{"illegal_ext", 7'b0010100, 1'b1, 1'b1, 32'h500, 32'h504, 32'hFFFF_FFFF,
                 32'h1808, 32'h301, 32'h0, 1'b1, 5, 32'h300, 32'h500, 32'd2, 32'hFFFF_FFFF,
                 32'h1880, 4};
    vecs[3]  = '{"ext_soft_tmr", 7'b0000111, 1'b1, 1'b1, 32'h84, 32'h88, 32'h13,
                 32'h8, 32'h301, 32'h0, 1'b1, 5, 32'h32C, 32'h88, 32'h8000_000B, 32'h0,
                 32'h80, 4};
    vecs[4]  = '{"soft_direct", 7'b0000010, 1'b1, 1'b1, 32'h1FFC, 32'h2000, 32'h13,
                 32'h8, 32'h400, 32'h0, 1'b1, 5, 32'h400, 32'h2000, 32'h8000_0003, 32'h0,
                 32'h80, 4};
    vecs[5]  = '{"ebreak_ecall", 7'b1100000, 1'b0, 1'b1, 32'h600, 32'h604, 32'h0010_0073,
                 32'h0, 32'h703, 32'h0, 1'b1, 5, 32'h700, 32'h600, 32'd3, 32'h600, 32'h0, 4};
    vecs[6]  = '{"irq_mie0", 7'b0000001, 1'b1, 1'b0, 32'h700, 32'h704, 32'h13,
                 32'h0, 32'h400, 32'h0, 1'b0, -1, 32'h700, 32'h0, 32'hFF, 32'hAAAA_AAAA,
                 32'h0, 0};
    vecs[7]  = '{"irq_no_hx", 7'b0000100, 1'b0, 1'b1, 32'h700, 32'h704, 32'h13,
                 32'h8, 32'h400, 32'h0, 1'b0, -1, 32'h700, 32'h0, 32'hFF, 32'hAAAA_AAAA,
                 32'h8, 0};
    vecs[8]  = '{"mret", 7'b0001000, 1'b0, 1'b1, 32'h800, 32'h804, 32'h3020_0073,
                 32'h80, 32'h200, 32'h1234, 1'b1, 2, 32'h1234, 32'h1234, 32'hFF,
                 32'hAAAA_AAAA, 32'h88, 1};
    vecs[9]  = '{"mret_ecall", 7'b1001000, 1'b0, 1'b1, 32'h900, 32'h904, 32'h73,
                 32'h88, 32'h200, 32'h1234, 1'b1, 5, 32'h200, 32'h900, 32'd11, 32'h0,
                 32'h80, 4};
    vecs[10] = '{"mret_tmr", 7'b0001001, 1'b1, 1'b1, 32'hA00, 32'hA04, 32'h3020_0073,
                 32'h0, 32'h200, 32'h1237, 1'b1, 2, 32'h1234, 32'h1237, 32'hFF,
                 32'hAAAA_AAAA, 32'h80, 1};

    rst_n          = 1'b0;
    load_en        = 1'b0;
    ld_mstatus     = 32'h0;
    ld_mtvec       = 32'h0;
    ld_mepc        = 32'h0;
    hx_valid       = 1'b0;
    mstatus_MIE3_i = 1'b0;
    inst_pc_i      = 32'h0;
    next_pc_i      = 32'h0;
    inst_i         = 32'h0;
    set_ev(7'b0);

    // Reset state, including an exception raised while reset is held.
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    ecall_i = 1'b1;
    #1;
    chk({"reset_ecall", " stall"}, {31'b0, trap_stall_o}, 32'h0);
    ecall_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // Reset in W_MCAUSE: sequence aborts, mepc keeps its new value, mcause untouched.
    load_csrs(32'h8, 32'h200, 32'h0);
    ecall_i   = 1'b1;
    inst_pc_i = 32'h100;
    next_pc_i = 32'h104;
    @(negedge clk);
    ecall_i = 1'b0;
    @(negedge clk);
    chk("midrst pre we", {31'b0, trap_csr_we_o}, 32'h1);
    chk("midrst pre addr", {20'b0, trap_csr_addr_o}, 32'h342);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    chk_all_zero("midrst held");
    rst_n = 1'b1;
    chk("midrst mepc kept", csr_mepc, 32'h100);
    chk("midrst mcause untouched", csr_mcause, 32'hFF);
    chk("midrst mstatus untouched", csr_mstatus, 32'h8);
    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
